// File: rtl/irq_priority_encoder_if.sv
// Signal bundle between the interrupt encoder and the CPU/peripheral side.
// slave is the encoder's view; master is the driver (CPU or bench) view.
interface irq_priority_encoder_if #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned ID_W    = 3
);
    logic [NUM_IRQ-1:0] irq_in;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic               ack;
    logic               eoi;
    logic               cpu_irq;
    logic [ID_W-1:0]    irq_id;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;

    modport slave (
        input  irq_in, mask_we, mask_wdata, ack, eoi,
        output cpu_irq, irq_id, in_service, pending, mask
    );

    modport master (
        output irq_in, mask_we, mask_wdata, ack, eoi,
        input  cpu_irq, irq_id, in_service, pending, mask
    );
endinterface

// File: rtl/irq_priority_encoder.sv
// Edge-capturing, maskable interrupt front end: lowest eligible index is
// presented to the CPU through a request / ack / end-of-interrupt handshake.
module irq_priority_encoder #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    irq_priority_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [ID_W-1:0]    irq_id_q;

    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clear_vec;
    logic [ID_W-1:0]    enc_id;
    logic               enc_found;
    logic               take_ack;

    assign edge_det = bus.irq_in & ~irq_q;
    assign eligible = pending_q & ~mask_q;
    assign take_ack = (state_q == REQ) && bus.ack;

    always_comb begin
        enc_id    = '0;
        enc_found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && !enc_found) begin
                enc_id    = ID_W'(i);
                enc_found = 1'b1;
            end
        end
    end

    always_comb begin
        clear_vec = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            clear_vec[i] = take_ack && (irq_id_q == ID_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enc_found) state_d = REQ;
            REQ:     if (bus.ack)   state_d = SERVICE;
            SERVICE: if (bus.eoi)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_irq    = (state_q == REQ);
        bus.in_service = (state_q == SERVICE);
    end

    // Edge set is applied after the ack clear so a colliding new edge survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            irq_id_q  <= '0;
        end else begin
            irq_q     <= bus.irq_in;
            pending_q <= (pending_q & ~clear_vec) | edge_det;
            if (bus.mask_we) begin
                mask_q <= bus.mask_wdata;
            end
            if ((state_q == IDLE) && enc_found) begin
                irq_id_q <= enc_id;
            end
        end
    end

    assign bus.irq_id  = irq_id_q;
    assign bus.pending = pending_q;
    assign bus.mask    = mask_q;
endmodule

// File: tb/tb_irq_priority_encoder.sv
// Directed bench for irq_priority_encoder: a cycle-level behavioural model is
// compared every cycle, with hand-computed literal checks along the way.
module tb_irq_priority_encoder;
    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    irq_priority_encoder_if #(.NUM_IRQ(N), .ID_W(W)) bus ();

    irq_priority_encoder #(.NUM_IRQ(N), .ID_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: phase 0 = nothing presented, 1 = presenting, 2 = servicing.
    logic [N-1:0] m_pend, m_mask, m_prev;
    int           m_phase;
    int           m_id;

    always @(posedge clk or posedge rst) begin
        logic [N-1:0] rises, elig, lowest, clr;
        int           idx;
        if (rst) begin
            m_pend  = '0;
            m_mask  = '0;
            m_prev  = '0;
            m_phase = 0;
            m_id    = 0;
        end else begin
            rises = bus.irq_in & ~m_prev;
            elig  = m_pend & ~m_mask;
            clr   = '0;
            if (m_phase == 0) begin
                if (elig != 0) begin
                    lowest = elig & (~elig + 8'd1);
                    idx = 0;
                    while (lowest > 8'd1) begin
                        lowest = lowest >> 1;
                        idx++;
                    end
                    m_id    = idx;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (bus.ack) begin
                    clr     = 8'd1 << m_id;
                    m_phase = 2;
                end
            end else if (bus.eoi) begin
                m_phase = 0;
            end
            m_pend = (m_pend & ~clr) | rises;
            if (bus.mask_we) m_mask = bus.mask_wdata;
            m_prev = bus.irq_in;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_cpu_irq", 32'(bus.cpu_irq), 32'(m_phase == 1));
            check("model_in_service", 32'(bus.in_service), 32'(m_phase == 2));
            check("model_irq_id", 32'(bus.irq_id), 32'(m_id));
            check("model_pending", 32'(bus.pending), 32'(m_pend));
            check("model_mask", 32'(bus.mask), 32'(m_mask));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        bus.irq_in = '0;
        bus.mask_we = 1'b0;
        bus.mask_wdata = '0;
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        cyc(2);
        check("rst_cpu_irq", 32'(bus.cpu_irq), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_irq_id", 32'(bus.irq_id), 32'd0);
        rst = 1'b0;
        cyc(1);

        // Single request on line 4
        bus.irq_in = 8'h10; cyc(1); bus.irq_in = '0;
        check("single_pending", 32'(bus.pending), 32'h10);
        check("single_no_irq_yet", 32'(bus.cpu_irq), 32'd0);
        cyc(1);
        check("single_cpu_irq", 32'(bus.cpu_irq), 32'd1);
        check("single_id", 32'(bus.irq_id), 32'd4);
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
        check("single_ack_pending", 32'(bus.pending), 32'h00);
        check("single_in_service", 32'(bus.in_service), 32'd1);
        check("single_ack_cpu_irq", 32'(bus.cpu_irq), 32'd0);
        cyc(2);
        bus.eoi = 1'b1; cyc(1); bus.eoi = 1'b0;
        check("single_eoi_in_service", 32'(bus.in_service), 32'd0);
        check("single_eoi_cpu_irq", 32'(bus.cpu_irq), 32'd0);
        cyc(2);

        // Priority: lines 2 and 7 together
        bus.irq_in = 8'h84; cyc(1); bus.irq_in = '0; cyc(1);
        check("prio_id_first", 32'(bus.irq_id), 32'd2);
        check("prio_pending", 32'(bus.pending), 32'h84);
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
        check("prio_pending_after_ack", 32'(bus.pending), 32'h80);
        bus.eoi = 1'b1; cyc(1); bus.eoi = 1'b0;
        check("prio_idle_after_eoi", 32'(bus.cpu_irq), 32'd0);
        cyc(1);
        check("prio_second_req", 32'(bus.cpu_irq), 32'd1);
        check("prio_id_second", 32'(bus.irq_id), 32'd7);
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
        check("prio_pending_empty", 32'(bus.pending), 32'h00);
        bus.eoi = 1'b1; cyc(1); bus.eoi = 1'b0;
        cyc(2);

        // Masking
        bus.mask_we = 1'b1; bus.mask_wdata = 8'h01; cyc(1); bus.mask_we = 1'b0;
        check("mask_written", 32'(bus.mask), 32'h01);
        bus.irq_in = 8'h01; cyc(1); bus.irq_in = '0;
        check("mask_pending", 32'(bus.pending), 32'h01);
        cyc(10);
        check("mask_no_irq", 32'(bus.cpu_irq), 32'd0);
        bus.mask_we = 1'b1; bus.mask_wdata = 8'h00; cyc(1); bus.mask_we = 1'b0;
        check("unmask_old_mask_used", 32'(bus.cpu_irq), 32'd0);
        cyc(1);
        check("unmask_cpu_irq", 32'(bus.cpu_irq), 32'd1);
        check("unmask_id", 32'(bus.irq_id), 32'd0);
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
        bus.eoi = 1'b1; cyc(1); bus.eoi = 1'b0;
        cyc(2);

        // Set wins over ack clear on the same line
        bus.irq_in = 8'h08; cyc(1); bus.irq_in = '0; cyc(1);
        check("collide_id", 32'(bus.irq_id), 32'd3);
        bus.irq_in = 8'h08; bus.ack = 1'b1; cyc(1); bus.ack = 1'b0; bus.irq_in = '0;
        check("collide_pending", 32'(bus.pending), 32'h08);
        check("collide_in_service", 32'(bus.in_service), 32'd1);
        bus.eoi = 1'b1; cyc(1); bus.eoi = 1'b0; cyc(1);
        check("collide_represent", 32'(bus.cpu_irq), 32'd1);
        check("collide_represent_id", 32'(bus.irq_id), 32'd3);
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
        bus.eoi = 1'b1; cyc(1); bus.eoi = 1'b0;
        cyc(2);

        // Held level and stray handshakes
        bus.irq_in = 8'h20; cyc(5);
        check("held_id", 32'(bus.irq_id), 32'd5);
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
        cyc(10);
        bus.eoi = 1'b1; cyc(1); bus.eoi = 1'b0;
        cyc(3);
        check("held_no_repeat", 32'(bus.cpu_irq), 32'd0);
        check("held_pending_clear", 32'(bus.pending), 32'h00);
        bus.irq_in = '0;
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;
        check("stray_ack_idle", 32'(bus.in_service), 32'd0);
        bus.irq_in = 8'h02; cyc(1); bus.irq_in = '0; cyc(1);
        check("stray_req_id", 32'(bus.irq_id), 32'd1);
        bus.eoi = 1'b1; cyc(1); bus.eoi = 1'b0;
        check("stray_eoi_req", 32'(bus.cpu_irq), 32'd1);
        check("stray_eoi_no_service", 32'(bus.in_service), 32'd0);
        bus.ack = 1'b1; cyc(1); bus.ack = 1'b0;

        // Async reset while servicing, with mask and pending populated
        bus.mask_we = 1'b1; bus.mask_wdata = 8'h40; bus.irq_in = 8'h40; cyc(1);
        bus.mask_we = 1'b0; bus.irq_in = '0;
        cyc(1);
        check("pre_reset_service", 32'(bus.in_service), 32'd1);
        check("pre_reset_pending", 32'(bus.pending), 32'h40);
        #3 rst = 1'b1;
        #1;
        check("async_cpu_irq", 32'(bus.cpu_irq), 32'd0);
        check("async_in_service", 32'(bus.in_service), 32'd0);
        check("async_pending", 32'(bus.pending), 32'h00);
        check("async_mask", 32'(bus.mask), 32'h00);
        check("async_irq_id", 32'(bus.irq_id), 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        bus.irq_in = 8'h01; cyc(1); bus.irq_in = '0; cyc(1);
        check("post_reset_req", 32'(bus.cpu_irq), 32'd1);
        check("post_reset_id", 32'(bus.irq_id), 32'd0);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/irq_priority_encoder.md
Name: irq_priority_encoder

Overview:
- Interrupt front end for the MIPS core: the encode direction that complements the existing one-hot decoder.
- Captures rising edges on NUM_IRQ request lines into a pending register and applies a software mask.
- Priority-encodes the result into a binary ID (lowest index wins).
- Runs a request/acknowledge/end-of-interrupt handshake with the CPU. Sits between peripherals and the CPU exception logic.

Parameters:
- NUM_IRQ, 8, number of request lines.
- ID_W, 3, width of encoded ID; must equal ceil(log2(NUM_IRQ)).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- irq_in  input  NUM_IRQ  peripheral request lines, synchronous to clk.
- mask_we  input  1  write strobe for mask register.
- mask_wdata  input  NUM_IRQ  new mask value; bit=1 masks that line.
- ack  input  1  CPU accepts the presented interrupt.
- eoi  input  1  CPU end-of-interrupt.
- cpu_irq  output  1  interrupt request to CPU.
- irq_id  output  ID_W  encoded ID of the presented/in-service interrupt.
- in_service  output  1  high while CPU is servicing an interrupt.
- pending  output  NUM_IRQ  pending register, for status reads.
- mask  output  NUM_IRQ  current mask register.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, on rst.
- Reset values: irq_q=0, pending=0, mask=0 (all enabled), state=IDLE, cpu_irq=0, irq_id=0, in_service=0.
- Edge capture:
  - irq_q registers irq_in every cycle.
  - edge = irq_in & ~irq_q.
  - pending[i] sets on any posedge where edge[i]=1, regardless of mask.
  - A level held high produces exactly one edge.
- Mask: mask loads mask_wdata on posedge when mask_we=1. Arbitration in the same cycle uses the old mask.
- Eligible set = pending & ~mask. Priority encode: lowest set index.
- FSM (states IDLE, REQ, SERVICE):
  - IDLE: if the eligible set is nonzero, latch irq_id = encoded index and go to REQ. Otherwise stay.
  - REQ: cpu_irq=1, irq_id held stable (no retraction, even if the line becomes masked). On ack: clear pending[irq_id], go to SERVICE.
  - SERVICE: in_service=1, cpu_irq=0, irq_id held. On eoi: go to IDLE.
- Ignored inputs: ack is ignored in IDLE and SERVICE. eoi is ignored in IDLE and REQ.
- Outputs: cpu_irq and in_service are decoded from registered state, so they are glitch-free.
- Latency: irq_in first sampled high at posedge k → pending set after k → REQ and cpu_irq=1 after k+1 (2 cycles).
- ack at posedge m → cpu_irq=0 and in_service=1 after m.
- eoi at posedge e → IDLE after e. If eligible interrupts remain, cpu_irq=1 again after e+1. No back-to-back REQ without passing IDLE.
- Simultaneous set and clear: a new edge on line i in the same cycle that ack clears pending[i] → set wins, pending[i]=1.
- Arrival while busy: a higher-priority edge arriving during REQ or SERVICE only sets pending. No preemption, no change to irq_id.
- All lines masked: pending still accumulates and cpu_irq stays 0. Unmasking later triggers the normal IDLE→REQ path.
- Reset mid-operation: asynchronously returns everything to reset values. Pending edges are lost.
- Width rule: irq_id is zero-extended index, ID_W bits. Indices ≥ NUM_IRQ never produced.

Test Plan:
- Single request: reset, pulse irq_in=8'h10 at k → pending=8'h10 after k, cpu_irq=1 and irq_id=4 after k+1. Then ack → pending=0, in_service=1. Then eoi → IDLE, cpu_irq=0.
- Priority: irq_in=8'h84 in one cycle → irq_id=2. After ack and eoi → irq_id=7 presented two cycles after eoi, pending=8'h80 → 8'h00 after second ack.
- Masking: mask write 8'h01, then irq_in=8'h01 → pending=8'h01, cpu_irq stays 0 for 10 cycles. Mask write 8'h00 → cpu_irq=1 with irq_id=0 two cycles later.
- Set-wins collision: in REQ with irq_id=3, ack in the same cycle as a new rising edge on line 3 → pending[3]=1 after ack. After eoi, ID 3 is re-presented.
- Held level and stray handshakes: irq_in[5] held high 20 cycles → only one pending set. After eoi, cpu_irq stays 0. ack in IDLE and eoi in REQ → no state change.
- Async reset mid-SERVICE: assert rst between clock edges → cpu_irq, in_service, pending, mask, irq_id=0 immediately, without waiting for clk.
